// File: rtl/param_counter_bank_pkg.sv
// Shared encodings for the parameterised counter bank: count mode and direction.
package param_counter_bank_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..div and emits a registered one-cycle tick
// when the count reaches div.
module tick_prescaler #(
  parameter int PRE_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tick_d = 1'b0;
    cnt_d  = cnt_q + PRE_W'(1);
    if (cnt_q == div) begin
      tick_d = 1'b1;
      cnt_d  = '0;
    end else if (cnt_q > div) begin
      // div was lowered under the running count: restart silently
      cnt_d = '0;
    end
  end

  // NOTE: reset is asynchronous active-low, so clearing takes effect without
  // a clock; state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/param_counter_bank.sv
// Bank of N_CH independent up/down counters advanced by a shared prescaler
// tick, with wrap/saturate boundary handling and an LED readback mux.
module param_counter_bank
  import param_counter_bank_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int WIDTH  = 4,
  parameter  int PRE_W  = 24,
  localparam int LSEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PRE_W-1:0]      prescale_div,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       dir,
  input  logic                  sat_mode,
  input  logic [N_CH-1:0]       load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clear,
  input  logic [LSEL_W-1:0]     led_sel,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       bound,
  output logic                  tick,
  output logic [WIDTH-1:0]      leds
);

  localparam logic [WIDTH-1:0]  MAX_CNT = '1;
  localparam logic [LSEL_W:0]   N_CH_L  = (LSEL_W + 1)'(N_CH);

  logic             tick_w;
  mode_e            mode;
  logic [WIDTH-1:0] cnt_arr [N_CH];
  logic [WIDTH-1:0] leds_q, leds_d;

  assign mode = mode_e'(sat_mode);

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (prescale_div),
    .tick  (tick_w)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             bound_q, bound_d;
    logic             at_lim;

    always_comb begin
      cnt_d   = cnt_q;
      bound_d = 1'b0;
      at_lim  = (dir_e'(dir[i]) == DIR_UP) ? (cnt_q == MAX_CNT) : (cnt_q == '0);
      if (clear) begin
        cnt_d = '0;
      end else if (load[i]) begin
        cnt_d = load_val;
      end else if (tick_w && en[i]) begin
        bound_d = at_lim;
        // saturate holds at the limit; wrap relies on modulo arithmetic
        if (at_lim && mode == MODE_SAT) cnt_d = cnt_q;
        else if (dir_e'(dir[i]) == DIR_UP) cnt_d = cnt_q + WIDTH'(1);
        else cnt_d = cnt_q - WIDTH'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        bound_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        bound_q <= bound_d;
      end
    end

    assign cnt_arr[i]                = cnt_q;
    assign count[i*WIDTH +: WIDTH]   = cnt_q;
    assign bound[i]                  = bound_q;
  end

  // out-of-range selects read as zero rather than an undefined channel
  always_comb begin
    leds_d = '0;
    if ({1'b0, led_sel} < N_CH_L) leds_d = cnt_arr[led_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) leds_q <= '0;
    else        leds_q <= leds_d;
  end

  assign leds = leds_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_param_counter_bank.sv
// Self-checking bench for param_counter_bank (N_CH=4, WIDTH=4): directed
// scenarios plus randomized traffic against an integer reference model.
module tb_param_counter_bank;

  localparam int N_CH  = 4;
  localparam int WIDTH = 4;
  localparam int PRE_W = 24;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [PRE_W-1:0]      prescale_div;
  logic [N_CH-1:0]       en, dir, load;
  logic                  sat_mode, clear;
  logic [WIDTH-1:0]      load_val;
  logic [1:0]            led_sel;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       bound;
  logic                  tick;
  logic [WIDTH-1:0]      leds;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_p;
  int m_tick;
  int m_cnt [N_CH];
  int m_bound [N_CH];
  int m_leds;

  always #5 clk = ~clk;

  param_counter_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prescale_div (prescale_div),
    .en           (en),
    .dir          (dir),
    .sat_mode     (sat_mode),
    .load         (load),
    .load_val     (load_val),
    .clear        (clear),
    .led_sel      (led_sel),
    .count        (count),
    .bound        (bound),
    .tick         (tick),
    .leds         (leds)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [N_CH*WIDTH-1:0] ev;
    logic [N_CH-1:0]       eb;
    for (int c = 0; c < N_CH; c++) begin
      ev[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
      eb[c]                = (m_bound[c] != 0);
    end
    check("count", 32'(count), 32'(ev));
    check("bound", 32'(bound), 32'(eb));
    check("tick",  32'(tick),  32'(m_tick));
    check("leds",  32'(leds),  32'(m_leds));
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic step();
    int div;
    int n_cnt [N_CH];
    int n_bound [N_CH];
    int v;
    div = int'(prescale_div);
    for (int c = 0; c < N_CH; c++) begin
      n_cnt[c]   = m_cnt[c];
      n_bound[c] = 0;
      if (clear) n_cnt[c] = 0;
      else if (load[c]) n_cnt[c] = int'(load_val);
      else if (m_tick != 0 && en[c]) begin
        v = m_cnt[c] + (dir[c] ? 1 : -1);
        if (v > MAXV || v < 0) begin
          n_bound[c] = 1;
          if (sat_mode) v = (v < 0) ? 0 : MAXV;
          else          v = (v < 0) ? MAXV : 0;
        end
        n_cnt[c] = v;
      end
    end
    m_leds = (int'(led_sel) < N_CH) ? m_cnt[led_sel] : 0;
    m_tick = (m_p == div) ? 1 : 0;
    m_p    = (m_p >= div) ? 0 : m_p + 1;
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c]   = n_cnt[c];
      m_bound[c] = n_bound[c];
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_bound", 32'(bound), 32'd0);
    check("rst_tick",  32'(tick),  32'd0);
    check("rst_leds",  32'(leds),  32'd0);
    m_p = 0; m_tick = 0; m_leds = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c]   = 0;
      m_bound[c] = 0;
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int k;
    prescale_div = 24'd3;
    en = '0; dir = '0; load = '0; load_val = '0;
    sat_mode = 1'b0; clear = 1'b0; led_sel = '0;
    do_reset();

    // prescaler period 4, then held high with div = 0
    t = 0;
    repeat (16) begin step(); t += int'(tick); end
    check("ticks_div3", 32'(t), 32'd4);
    prescale_div = 24'd0;
    step();
    t = 0;
    repeat (8) begin step(); t += int'(tick); end
    check("ticks_div0", 32'(t), 32'd8);

    // ch0 up, wrap, from 14
    load = 4'b0001; load_val = 4'd14;
    step();
    check("ch0_load", 32'(count[3:0]), 32'd14);
    load = '0; en = 4'b0001; dir = 4'b0001; sat_mode = 1'b0;
    step();
    check("ch0_15", 32'(count[3:0]), 32'd15);
    check("ch0_nobound", 32'(bound[0]), 32'd0);
    step();
    check("ch0_wrap", 32'(count[3:0]), 32'd0);
    check("ch0_bound", 32'(bound[0]), 32'd1);
    en = '0;
    step();
    check("ch0_bound_end", 32'(bound[0]), 32'd0);

    // ch1 down, saturate, from 1
    load = 4'b0010; load_val = 4'd1;
    step();
    load = '0; en = 4'b0010; dir = 4'b0000; sat_mode = 1'b1;
    step();
    check("ch1_t1", 32'({count[7:4], bound[1]}), 32'({4'd0, 1'b0}));
    step();
    check("ch1_t2", 32'({count[7:4], bound[1]}), 32'({4'd0, 1'b1}));
    step();
    check("ch1_t3", 32'({count[7:4], bound[1]}), 32'({4'd0, 1'b1}));

    // load beats tick; clear beats load
    en = 4'b0100; dir = 4'b0100; sat_mode = 1'b0; load = 4'b0100; load_val = 4'd9;
    step();
    check("ch2_load", 32'(count[11:8]), 32'd9);
    check("ch2_nobound", 32'(bound[2]), 32'd0);
    clear = 1'b1;
    step();
    check("ch2_clear", 32'(count[11:8]), 32'd0);
    clear = 1'b0; load = '0; en = '0;

    // LED readback latency
    load = 4'b1000; load_val = 4'd5;
    step();
    load = 4'b0001; load_val = 4'd2; led_sel = 2'd3;
    step();
    check("leds_ch3", 32'(leds), 32'd5);
    load = '0; led_sel = 2'd0;
    step();
    check("leds_ch0", 32'(leds), 32'd2);

    // reset while prescaler sits at 2 of 3
    prescale_div = 24'd3;
    k = 0;
    while (m_p != 2 && k < 10) begin step(); k++; end
    check("pre_at_2", 32'(m_p), 32'd2);
    do_reset();
    k = 0;
    while (k < 10) begin
      step();
      k++;
      if (tick) break;
    end
    check("first_tick", 32'(k), 32'd4);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      en       = N_CH'($urandom);
      dir      = N_CH'($urandom);
      sat_mode = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      load_val = WIDTH'($urandom);
      clear    = ($urandom_range(0, 15) == 0);
      led_sel  = 2'($urandom);
      if ($urandom_range(0, 19) == 0) prescale_div = PRE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_counter_bank.md
PARAM_COUNTER_BANK -- requirements
Module: param_counter_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent counter channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 4: bits per channel counter (2..32).
REQ-003 SHALL have parameter PRE_W, default 24: prescaler divider width.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port prescale_div  in  PRE_W  tick period minus one.
REQ-007 SHALL have port en  in  N_CH  per-channel count enable.
REQ-008 SHALL have port dir  in  N_CH  per-channel direction; 1 = up, 0 = down.
REQ-009 SHALL have port sat_mode  in  1  0 = wrap, 1 = saturate (all channels).
REQ-010 SHALL have port load  in  N_CH  per-channel synchronous load strobe.
REQ-011 SHALL have port load_val  in  WIDTH  value loaded by any asserted load bit.
REQ-012 SHALL have port clear  in  1  synchronous clear of all channels.
REQ-013 SHALL have port led_sel  in  $clog2(N_CH)  channel routed to leds.
REQ-014 SHALL have port count  out  N_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port bound  out  N_CH  one-cycle pulse per channel on boundary event.
REQ-016 SHALL have port tick  out  1  registered prescaler tick.
REQ-017 SHALL have port leds  out  WIDTH  registered copy of selected channel count.

Function
REQ-018 Prescaler SHALL count 0..prescale_div and assert tick for exactly one cycle when its counter equals prescale_div, then restart at 0.
REQ-019 prescale_div = 0 SHALL assert tick every cycle.
REQ-020 If prescale_div is lowered below the current prescaler count, the prescaler SHALL restart at 0 on the next cycle with no tick.
REQ-021 A channel SHALL update on the edge where tick = 1 and en[i] = 1: +1 if dir[i] = 1, -1 if dir[i] = 0.
REQ-022 Wrap mode: increment from 2^WIDTH-1 SHALL yield 0, decrement from 0 SHALL yield 2^WIDTH-1; bound[i] pulses in the following cycle.
REQ-023 Saturate mode: counts SHALL hold at 2^WIDTH-1 (up) or 0 (down); bound[i] pulses each tick that attempts to pass the limit.
REQ-024 Priority per channel SHALL be clear > load[i] > tick count; load or clear suppresses bound[i] for that cycle.
REQ-025 Loaded value SHALL appear on count one cycle after load[i] is sampled.
REQ-026 Changing dir or sat_mode SHALL take effect on the next tick with no glitch in count.
REQ-027 leds SHALL equal count of channel led_sel with one cycle latency; led_sel >= N_CH SHALL drive leds = 0.
REQ-028 Channels SHALL be fully independent; simultaneous bound events on several channels SHALL all be reported.

Reset
REQ-029 rst_n low SHALL immediately force count = 0, bound = 0, tick = 0, leds = 0, prescaler counter = 0.
REQ-030 Reset asserted mid-count SHALL discard any pending tick; after release, the first tick occurs prescale_div+1 cycles later.

Structure
REQ-031 Shared package SHALL hold the mode encoding (MODE_WRAP = 0, MODE_SAT = 1) and the direction constants (DIR_UP, DIR_DOWN).
REQ-032 Prescaler SHALL be a separate sub-module named tick_prescaler (parameter PRE_W; ports clk, rst_n, div, tick); channels SHALL be a generate loop in the top module.

Verification (N_CH=4, WIDTH=4)
REQ-033 prescale_div = 3 -> tick pulses every 4 cycles; prescale_div = 0 -> tick held high.
REQ-034 ch0 up, wrap, start 14, two ticks -> count 15 then 0; bound[0] pulses once after the 15->0 update.
REQ-035 ch1 down, saturate, load_val = 1 loaded, three ticks -> count 0, 0, 0; bound[1] pulses on ticks 2 and 3.
REQ-036 load[2] = 1, load_val = 9 and tick in the same cycle -> count[2] = 9, no increment, no bound; clear together with load -> count[2] = 0.
REQ-037 led_sel = 3 with count[3] = 5 -> leds = 5 one cycle later; led_sel change -> leds follows one cycle later.
REQ-038 rst_n pulsed low while prescaler at 2 of 3 -> all outputs 0 immediately; first tick 4 cycles after release.
